glb_proc_arbiter: RTL and testbench

- Multi-channel successor to the single processor packet port of the global buffer.
- Merges NUM_CH processor request channels onto one bank-side processor packet using round-robin arbitration.
- Tracks outstanding reads in an in-order tag FIFO and routes each bank read response back to the channel that issued it.
- Sits between the processor/AXI front end and the GLB bank processor port.

---
 rtl/glb_proc_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_glb_proc_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_proc_arbiter.sv
// Round-robin merge of NUM_CH processor request channels onto the single GLB bank
// processor port, with an in-order read tag FIFO that steers responses back.
module glb_proc_arbiter #(
   parameter int NUM_CH          = 4,
   parameter int ADDR_WIDTH      = 22,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_CH-1:0]              ch_wr_en,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0] ch_wr_strb,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_wr_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wr_data,
   input  logic [NUM_CH-1:0]              ch_rd_en,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_rd_addr,
   output logic [NUM_CH-1:0]              ch_req_ready,
   output logic [DATA_WIDTH-1:0]          ch_rd_data,
   output logic [NUM_CH-1:0]              ch_rd_data_valid,
   output logic                           bank_wr_en,
   output logic [DATA_WIDTH/8-1:0]        bank_wr_strb,
   output logic [ADDR_WIDTH-1:0]          bank_wr_addr,
   output logic [DATA_WIDTH-1:0]          bank_wr_data,
   output logic                           bank_rd_en,
   output logic [ADDR_WIDTH-1:0]          bank_rd_addr,
   input  logic [DATA_WIDTH-1:0]          bank_rd_data,
   input  logic                           bank_rd_data_valid,
   output logic                           err_proto,
   output logic                           err_underflow
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CH_W       = $clog2(NUM_CH);
   localparam int PTR_W      = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0]     eligible;
   logic                  fifo_full;
   logic                  grant_vld;
   logic [CH_W-1:0]       grant_idx;
   logic [CH_W-1:0]       scan_idx;
   logic                  grant_wr, grant_rd, grant_both;

   logic [STRB_WIDTH-1:0] sel_wr_strb;
   logic [ADDR_WIDTH-1:0] sel_wr_addr;
   logic [DATA_WIDTH-1:0] sel_wr_data;
   logic [ADDR_WIDTH-1:0] sel_rd_addr;

   logic                  bank_wr_en_q, bank_rd_en_q;
   logic [STRB_WIDTH-1:0] bank_wr_strb_q;
   logic [ADDR_WIDTH-1:0] bank_wr_addr_q, bank_rd_addr_q;
   logic [DATA_WIDTH-1:0] bank_wr_data_q;

   logic [CH_W-1:0]       tag_mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  push, pop, underflow;
   logic [CH_W-1:0]       head_tag;

   logic [NUM_CH-1:0]     rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  err_proto_q, err_underflow_q;

   // A pop in the same cycle must not unblock a read, so fullness uses the registered count.
   assign fifo_full = (count_q == CNT_FULL);
   assign eligible  = ch_wr_en | (ch_rd_en & {NUM_CH{~fifo_full}});

   // NOTE: combinational blocks assign every output a default first and use blocking
   // assignments; any path that skipped an assignment would infer a latch.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
         if (!grant_vld && eligible[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      sel_wr_strb = '0;
      sel_wr_addr = '0;
      sel_wr_data = '0;
      sel_rd_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == CH_W'(i)) begin
            sel_wr_strb = ch_wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
            sel_wr_addr = ch_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wr_data = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_rd_addr = ch_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // A channel raising both enables gets its write; the read is dropped.
   assign grant_wr   = grant_vld & ch_wr_en[grant_idx];
   assign grant_rd   = grant_vld & ~ch_wr_en[grant_idx] & ch_rd_en[grant_idx];
   assign grant_both = grant_vld & ch_wr_en[grant_idx] & ch_rd_en[grant_idx];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
   end

   assign push      = grant_rd;
   assign pop       = bank_rd_data_valid & (count_q != '0);
   assign underflow = bank_rd_data_valid & (count_q == '0);
   assign head_tag  = tag_mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q        <= '0;
         bank_wr_en_q    <= 1'b0;
         bank_rd_en_q    <= 1'b0;
         bank_wr_strb_q  <= '0;
         bank_wr_addr_q  <= '0;
         bank_wr_data_q  <= '0;
         bank_rd_addr_q  <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         rsp_valid_q     <= '0;
         rsp_data_q      <= '0;
         err_proto_q     <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         bank_wr_en_q <= grant_wr;
         bank_rd_en_q <= grant_rd;
         if (grant_wr) begin
            bank_wr_strb_q <= sel_wr_strb;
            bank_wr_addr_q <= sel_wr_addr;
            bank_wr_data_q <= sel_wr_data;
         end
         if (grant_rd) begin
            bank_rd_addr_q <= sel_rd_addr;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            rsp_data_q <= bank_rd_data;
         end
         count_q     <= count_d;
         rsp_valid_q <= pop ? (NUM_CH'(1) << head_tag) : '0;
         if (grant_both) begin
            err_proto_q <= 1'b1;
         end
         if (underflow) begin
            err_underflow_q <= 1'b1;
         end
      end
   end

   // NOTE: the tag array is deliberately not reset; only entries between rd_ptr_q and
   // wr_ptr_q are ever read, and those are always written first.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem_q[wr_ptr_q] <= grant_idx;
      end
   end

   // Grant is combinational, so it is also forced low while reset is held.
   assign ch_req_ready     = (grant_vld && reset_n) ? (NUM_CH'(1) << grant_idx) : '0;
   assign ch_rd_data       = rsp_data_q;
   assign ch_rd_data_valid = rsp_valid_q;
   assign bank_wr_en       = bank_wr_en_q;
   assign bank_wr_strb     = bank_wr_strb_q;
   assign bank_wr_addr     = bank_wr_addr_q;
   assign bank_wr_data     = bank_wr_data_q;
   assign bank_rd_en       = bank_rd_en_q;
   assign bank_rd_addr     = bank_rd_addr_q;
   assign err_proto        = err_proto_q;
   assign err_underflow    = err_underflow_q;

endmodule

// File: tb/tb_glb_proc_arbiter.sv
// Directed bench for glb_proc_arbiter: grant order, bank-side timing, read routing,
// FIFO-full blocking, sticky errors and mid-burst reset.
module tb_glb_proc_arbiter;

   localparam int NUM_CH = 4;
   localparam int AW     = 22;
   localparam int DW     = 64;
   localparam int SW     = DW / 8;
   localparam int MAXO   = 8;

   logic                 clk;
   logic                 reset_n;
   logic [NUM_CH-1:0]    ch_wr_en;
   logic [NUM_CH*SW-1:0] ch_wr_strb;
   logic [NUM_CH*AW-1:0] ch_wr_addr;
   logic [NUM_CH*DW-1:0] ch_wr_data;
   logic [NUM_CH-1:0]    ch_rd_en;
   logic [NUM_CH*AW-1:0] ch_rd_addr;
   logic [NUM_CH-1:0]    ch_req_ready;
   logic [DW-1:0]        ch_rd_data;
   logic [NUM_CH-1:0]    ch_rd_data_valid;
   logic                 bank_wr_en;
   logic [SW-1:0]        bank_wr_strb;
   logic [AW-1:0]        bank_wr_addr;
   logic [DW-1:0]        bank_wr_data;
   logic                 bank_rd_en;
   logic [AW-1:0]        bank_rd_addr;
   logic [DW-1:0]        bank_rd_data;
   logic                 bank_rd_data_valid;
   logic                 err_proto;
   logic                 err_underflow;

   int n_vec = 0;
   int n_err = 0;

   glb_proc_arbiter #(
      .NUM_CH          (NUM_CH),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .ch_wr_en           (ch_wr_en),
      .ch_wr_strb         (ch_wr_strb),
      .ch_wr_addr         (ch_wr_addr),
      .ch_wr_data         (ch_wr_data),
      .ch_rd_en           (ch_rd_en),
      .ch_rd_addr         (ch_rd_addr),
      .ch_req_ready       (ch_req_ready),
      .ch_rd_data         (ch_rd_data),
      .ch_rd_data_valid   (ch_rd_data_valid),
      .bank_wr_en         (bank_wr_en),
      .bank_wr_strb       (bank_wr_strb),
      .bank_wr_addr       (bank_wr_addr),
      .bank_wr_data       (bank_wr_data),
      .bank_rd_en         (bank_rd_en),
      .bank_rd_addr       (bank_rd_addr),
      .bank_rd_data       (bank_rd_data),
      .bank_rd_data_valid (bank_rd_data_valid),
      .err_proto          (err_proto),
      .err_underflow      (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      ch_wr_en   = '0;
      ch_rd_en   = '0;
      ch_wr_strb = '0;
      ch_wr_addr = '0;
      ch_wr_data = '0;
      ch_rd_addr = '0;
   endtask

   task automatic set_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
      ch_wr_en[ch]            = 1'b1;
      ch_wr_addr[ch*AW +: AW] = a;
      ch_wr_data[ch*DW +: DW] = d;
      ch_wr_strb[ch*SW +: SW] = s;
   endtask

   task automatic set_rd(input int ch, input logic [AW-1:0] a);
      ch_rd_en[ch]            = 1'b1;
      ch_rd_addr[ch*AW +: AW] = a;
   endtask

   function automatic logic [NUM_CH-1:0] onehot(input int ch);
      logic [NUM_CH-1:0] v;
      v = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   function automatic logic [AW-1:0] rr_addr(input int ch);
      return AW'(32'h10 * (ch + 1));
   endfunction

   initial begin
      reset_n            = 1'b0;
      bank_rd_data       = '0;
      bank_rd_data_valid = 1'b0;
      clear_req();

      // Reset state
      #3;
      check("rst_ready", ch_req_ready, 0);
      check("rst_bank_wr_en", bank_wr_en, 0);
      check("rst_bank_rd_en", bank_rd_en, 0);
      check("rst_rd_valid", ch_rd_data_valid, 0);
      check("rst_err_proto", err_proto, 0);
      check("rst_err_underflow", err_underflow, 0);
      step();
      step();
      reset_n = 1'b1;

      // Single write on ch2
      set_wr(2, 22'h100, 64'hDEAD_BEEF, 8'hFF);
      #1;
      check("wr_ready", ch_req_ready, 4'b0100);
      step();
      check("wr_bank_wr_en", bank_wr_en, 1);
      check("wr_bank_rd_en", bank_rd_en, 0);
      check("wr_bank_addr", bank_wr_addr, 22'h100);
      check("wr_bank_data", bank_wr_data, 64'hDEAD_BEEF);
      check("wr_bank_strb", bank_wr_strb, 8'hFF);
      clear_req();
      step();
      check("wr_idle_en", bank_wr_en, 0);
      check("wr_idle_addr_hold", bank_wr_addr, 22'h100);

      // Read routing: pointer is at 3, so ch1 then ch3
      set_rd(1, 22'h40);
      #1;
      check("rt_ready_ch1", ch_req_ready, 4'b0010);
      step();
      check("rt_bank_rd_en0", bank_rd_en, 1);
      check("rt_bank_rd_addr0", bank_rd_addr, 22'h40);
      clear_req();
      set_rd(3, 22'h80);
      #1;
      check("rt_ready_ch3", ch_req_ready, 4'b1000);
      step();
      check("rt_bank_rd_addr1", bank_rd_addr, 22'h80);
      clear_req();
      bank_rd_data       = 64'hAAAA;
      bank_rd_data_valid = 1'b1;
      step();
      check("rt_valid0", ch_rd_data_valid, 4'b0010);
      check("rt_data0", ch_rd_data, 64'hAAAA);
      bank_rd_data = 64'hBBBB;
      step();
      check("rt_valid1", ch_rd_data_valid, 4'b1000);
      check("rt_data1", ch_rd_data, 64'hBBBB);
      bank_rd_data_valid = 1'b0;
      step();
      check("rt_valid_idle", ch_rd_data_valid, 0);
      check("rt_data_hold", ch_rd_data, 64'hBBBB);

      // Round-robin fairness, bank answers each read four cycles after its grant
      for (int ch = 0; ch < NUM_CH; ch++) set_rd(ch, rr_addr(ch));
      for (int c = 0; c <= 16; c++) begin
         ch_rd_en           = (c < 12) ? '1 : '0;
         bank_rd_data_valid = (c >= 4 && c < 16);
         bank_rd_data       = 64'h1000 + 64'(c - 4);
         #1;
         if (c < 12) check("rr_ready", ch_req_ready, onehot(c % 4));
         else        check("rr_ready_idle", ch_req_ready, 0);
         if (c >= 1 && c <= 12) begin
            check("rr_bank_rd_en", bank_rd_en, 1);
            check("rr_bank_rd_addr", bank_rd_addr, rr_addr((c - 1) % 4));
         end
         if (c >= 5) begin
            check("rr_rsp_valid", ch_rd_data_valid, onehot((c - 5) % 4));
            check("rr_rsp_data", ch_rd_data, 64'h1000 + 64'(c - 5));
         end
         step();
      end
      clear_req();
      bank_rd_data_valid = 1'b0;
      step();

      // FIFO full: eight reads from ch0 with no response
      set_rd(0, 22'h200);
      for (int i = 0; i < MAXO; i++) begin
         #1;
         check("full_fill_ready", ch_req_ready, 4'b0001);
         step();
      end
      set_wr(1, 22'h300, 64'h1234, 8'h0F);
      #1;
      check("full_wr_granted", ch_req_ready, 4'b0010);
      step();
      check("full_bank_wr_en", bank_wr_en, 1);
      check("full_bank_rd_en", bank_rd_en, 0);
      check("full_bank_wr_addr", bank_wr_addr, 22'h300);
      ch_wr_en[1]        = 1'b0;
      bank_rd_data       = 64'h5555;
      bank_rd_data_valid = 1'b1;
      #1;
      check("full_pop_same_cycle", ch_req_ready, 0);
      step();
      check("full_pop_valid", ch_rd_data_valid, 4'b0001);
      check("full_pop_data", ch_rd_data, 64'h5555);
      bank_rd_data_valid = 1'b0;
      #1;
      check("full_freed_ready", ch_req_ready, 4'b0001);
      step();
      check("full_refill_rd_en", bank_rd_en, 1);
      check("full_refill_addr", bank_rd_addr, 22'h200);
      clear_req();
      for (int i = 0; i < MAXO; i++) begin
         bank_rd_data       = 64'(i);
         bank_rd_data_valid = 1'b1;
         step();
         check("full_drain_valid", ch_rd_data_valid, 4'b0001);
      end
      bank_rd_data_valid = 1'b0;
      step();
      check("full_no_underflow", err_underflow, 0);

      // Protocol error: ch0 raises both enables (pointer at 1)
      set_wr(0, 22'h3C, 64'hCAFE, 8'hFF);
      set_rd(0, 22'h3C);
      #1;
      check("proto_ready", ch_req_ready, 4'b0001);
      check("proto_err_before", err_proto, 0);
      step();
      check("proto_wr_en", bank_wr_en, 1);
      check("proto_rd_dropped", bank_rd_en, 0);
      check("proto_err_set", err_proto, 1);
      clear_req();
      step();
      check("proto_err_sticky", err_proto, 1);
      check("proto_wr_idle", bank_wr_en, 0);
      bank_rd_data       = 64'h9999;
      bank_rd_data_valid = 1'b1;
      step();
      check("unf_err_set", err_underflow, 1);
      check("unf_no_valid", ch_rd_data_valid, 0);
      bank_rd_data_valid = 1'b0;
      step();

      // Reset with three reads outstanding (pointer at 1)
      set_rd(1, 22'h11);
      set_rd(2, 22'h22);
      set_rd(3, 22'h33);
      for (int i = 1; i <= 3; i++) begin
         #1;
         check("mid_ready", ch_req_ready, onehot(i));
         step();
         ch_rd_en[i] = 1'b0;
      end
      check("mid_rd_en_before", bank_rd_en, 1);
      ch_rd_en[2] = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_ready", ch_req_ready, 0);
      check("mid_rst_rd_en", bank_rd_en, 0);
      check("mid_rst_rd_addr", bank_rd_addr, 0);
      check("mid_rst_wr_addr", bank_wr_addr, 0);
      check("mid_rst_wr_data", bank_wr_data, 0);
      check("mid_rst_rd_data", ch_rd_data, 0);
      check("mid_rst_err_proto", err_proto, 0);
      check("mid_rst_err_underflow", err_underflow, 0);
      clear_req();
      step();
      reset_n = 1'b1;
      step();
      bank_rd_data       = 64'h7777;
      bank_rd_data_valid = 1'b1;
      step();
      check("mid_late_underflow", err_underflow, 1);
      check("mid_late_no_valid", ch_rd_data_valid, 0);
      bank_rd_data_valid = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) set_wr(ch, 22'(ch), 64'(ch), 8'h01);
      #1;
      check("mid_ptr_restart", ch_req_ready, 4'b0001);
      step();
      clear_req();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
